// File: rtl/activation_stream_unit_pkg.sv
// Shared definitions for the activation stream unit: function codes, FSM encoding,
// and helpers that derive the pointwise thresholds and output levels from the element width.
package act_stream_pkg;

    localparam logic [2:0] ACT_RELU    = 3'd0;
    localparam logic [2:0] ACT_SIGMOID = 3'd1;
    localparam logic [2:0] ACT_TANH    = 3'd2;
    localparam logic [2:0] ACT_SOFTMAX = 3'd3;
    localparam logic [2:0] ACT_LEAKY   = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS  = 2'd1,
        ST_LOAD  = 2'd2,
        ST_DRAIN = 2'd3
    } act_state_e;

    // Breakpoint T = 2^(w-2)
    function automatic int act_thresh(input int w);
        return 2 ** (w - 2);
    endfunction

    // Full scale F = 2^(w-1)
    function automatic int act_full(input int w);
        return 2 ** (w - 1);
    endfunction

    // Output level num/den * F
    function automatic int act_level(input int w, input int num, input int den);
        return (act_full(w) * num) / den;
    endfunction

endpackage

// File: rtl/activation_stream_unit_if.sv
// Valid/ready beat stream of LANES signed elements with per-lane keep and end-of-vector marker.
interface activation_stream_unit_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 4
);
    logic                          valid;
    logic                          ready;
    logic [LANES*DATA_WIDTH-1:0]   data;
    logic [LANES-1:0]              keep;
    logic                          last;

    modport master (output valid, data, keep, last, input ready);
    modport slave  (input valid, data, keep, last, output ready);
endinterface

// File: rtl/activation_stream_unit_pointwise.sv
// Single-element combinational ReLU / sigmoid / tanh (4-level step approximations) and,
// when ACT_LEAKY_RELU_EN is defined, leaky ReLU. Reserved codes fall back to ReLU.
module act_lane_pointwise
    import act_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [2:0]                   func,
    input  logic signed [DATA_WIDTH-1:0] x,
    output logic signed [DATA_WIDTH-1:0] y
);

    localparam logic signed [DATA_WIDTH-1:0] T_POS   = DATA_WIDTH'(act_thresh(DATA_WIDTH));
    localparam logic signed [DATA_WIDTH-1:0] T_NEG   = -T_POS;
    localparam logic signed [DATA_WIDTH-1:0] SIG_HI  = DATA_WIDTH'(act_level(DATA_WIDTH, 3, 4));
    localparam logic signed [DATA_WIDTH-1:0] SIG_LO  = DATA_WIDTH'(act_level(DATA_WIDTH, 1, 4));
    localparam logic signed [DATA_WIDTH-1:0] TANH_HI = DATA_WIDTH'(act_level(DATA_WIDTH, 7, 8));
    localparam logic signed [DATA_WIDTH-1:0] TANH_LO = DATA_WIDTH'(act_level(DATA_WIDTH, 3, 8));

    // Odd-symmetric four-level staircase shared by sigmoid and tanh
    function automatic logic signed [DATA_WIDTH-1:0] step4(
        input logic signed [DATA_WIDTH-1:0] v,
        input logic signed [DATA_WIDTH-1:0] lo,
        input logic signed [DATA_WIDTH-1:0] hi
    );
        if (v < T_NEG)            return -hi;
        else if (v[DATA_WIDTH-1]) return -lo;
        else if (v < T_POS)       return lo;
        else                      return hi;
    endfunction

    always_comb begin
        y = x[DATA_WIDTH-1] ? '0 : x;
        case (func)
            ACT_SIGMOID: y = step4(x, SIG_LO, SIG_HI);
            ACT_TANH:    y = step4(x, TANH_LO, TANH_HI);
`ifdef ACT_LEAKY_RELU_EN
            ACT_LEAKY:   y = x[DATA_WIDTH-1] ? (x >>> 3) : x;
`endif
            default:     ;
        endcase
    end

endmodule

// File: rtl/activation_stream_unit.sv
// Streaming multi-lane activation unit: pointwise functions through a 1-stage register,
// softmax-approx by buffering a vector, tracking its max, then replaying clamp(x - max).
// Optional feature macro: ACT_LEAKY_RELU_EN (func_sel 4 = leaky ReLU).
module activation_stream_unit
    import act_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 4,
    parameter int MAX_BEATS  = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [2:0]                      func_sel,
    activation_stream_unit_if.slave         up,
    activation_stream_unit_if.master        dn,
    output logic                            busy,
    output logic                            err_overflow
);

    localparam int W  = DATA_WIDTH;
    localparam int AW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam int PW = $clog2(MAX_BEATS + 1);
    localparam logic signed [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W:0]   MIN_EXT = {2'b11, {(W-1){1'b0}}};

    act_state_e          state_q, state_d;
    logic [2:0]          func_q;
    logic [PW-1:0]       wr_ptr_q, rd_ptr_q, wr_idx;
    logic signed [W-1:0] max_q, max_d;
    logic                err_q;

    logic [LANES*W-1:0]  buf_data [MAX_BEATS];
    logic [LANES-1:0]    buf_keep [MAX_BEATS];
    logic [LANES*W-1:0]  rd_data, pw_data, sm_data;
    logic [LANES-1:0]    rd_keep;

    logic                out_valid_q, out_last_q;
    logic [LANES*W-1:0]  out_data_q;
    logic [LANES-1:0]    out_keep_q;

    logic in_fire, out_fire, start, start_sm, load_fire, load_end, overflow, pass_fire, drain_load;
    logic [2:0] func_eff;

    // Softmax difference is formed at W+1 bits so x - max never wraps before clamping
    function automatic logic signed [W-1:0] sub_clamp(
        input logic signed [W-1:0] x,
        input logic signed [W-1:0] m
    );
        logic signed [W:0] d;
        d = {x[W-1], x} - {m[W-1], m};
        if (d < MIN_EXT) return MIN_VAL;
        return d[W-1:0];
    endfunction

    assign in_fire  = up.valid && up.ready;
    assign out_fire = out_valid_q && dn.ready;
    // A beat accepted while the previous PASS vector's last beat is leaving starts a new vector
    assign start    = in_fire && (state_q == ST_IDLE ||
                                  (state_q == ST_PASS && out_valid_q && out_last_q));
    assign func_eff  = start ? func_sel : func_q;
    assign start_sm  = start && (func_sel == ACT_SOFTMAX);
    assign load_fire = in_fire && (state_q == ST_LOAD || start_sm);
    assign wr_idx    = start ? '0 : wr_ptr_q;
    assign load_end  = load_fire && (up.last || wr_idx == PW'(MAX_BEATS - 1));
    assign overflow  = load_fire && !up.last && wr_idx == PW'(MAX_BEATS - 1);
    assign pass_fire = in_fire && !load_fire;
    assign drain_load = (state_q == ST_DRAIN) && (!out_valid_q || dn.ready) && (rd_ptr_q < wr_ptr_q);

    assign rd_data = buf_data[rd_ptr_q[AW-1:0]];
    assign rd_keep = buf_keep[rd_ptr_q[AW-1:0]];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic signed [W-1:0] y;
        act_lane_pointwise #(.DATA_WIDTH(W)) u_pw (
            .func (func_eff),
            .x    (up.data[i*W +: W]),
            .y    (y)
        );
        assign pw_data[i*W +: W] = up.keep[i] ? y : '0;
        assign sm_data[i*W +: W] = rd_keep[i] ? sub_clamp(rd_data[i*W +: W], max_q) : '0;
    end

    always_comb begin
        max_d = start ? MIN_VAL : max_q;
        for (int i = 0; i < LANES; i++) begin
            if (up.keep[i] && $signed(up.data[i*W +: W]) > max_d) max_d = up.data[i*W +: W];
        end
    end

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_PASS: begin
                if (start)
                    state_d = start_sm ? (load_end ? ST_DRAIN : ST_LOAD) : ST_PASS;
                else if (state_q == ST_PASS && out_fire && out_last_q)
                    state_d = ST_IDLE;
            end
            ST_LOAD:  if (load_end) state_d = ST_DRAIN;
            ST_DRAIN: if (out_fire && out_last_q) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        up.ready = 1'b0;
        case (state_q)
            ST_IDLE, ST_LOAD: up.ready = 1'b1;
            ST_PASS:          up.ready = !out_valid_q || dn.ready;
            default:          up.ready = 1'b0;
        endcase
        busy = (state_q != ST_IDLE);
    end

    // Output register stage, shared by PASS and DRAIN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            func_q      <= ACT_RELU;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            max_q       <= MIN_VAL;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_keep_q  <= '0;
            out_data_q  <= '0;
        end else begin
            err_q <= overflow;
            if (start) begin
                func_q   <= func_sel;
                rd_ptr_q <= '0;
            end
            if (load_fire) begin
                wr_ptr_q <= wr_idx + PW'(1);
                max_q    <= max_d;
            end
            if (pass_fire) begin
                out_valid_q <= 1'b1;
                out_data_q  <= pw_data;
                out_keep_q  <= up.keep;
                out_last_q  <= up.last;
            end else if (drain_load) begin
                out_valid_q <= 1'b1;
                out_data_q  <= sm_data;
                out_keep_q  <= rd_keep;
                out_last_q  <= (rd_ptr_q + PW'(1) == wr_ptr_q);
                rd_ptr_q    <= rd_ptr_q + PW'(1);
            end else if (out_fire) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load_fire) begin
            buf_data[wr_idx[AW-1:0]] <= up.data;
            buf_keep[wr_idx[AW-1:0]] <= up.keep;
        end
    end

    assign dn.valid     = out_valid_q;
    assign dn.data      = out_data_q;
    assign dn.keep      = out_keep_q;
    assign dn.last      = out_last_q;
    assign err_overflow = err_q;

endmodule

// File: tb/tb_activation_stream_unit.sv
// Directed bench for activation_stream_unit (W=8, LANES=4, MAX_BEATS=16); honours ACT_LEAKY_RELU_EN.
module tb_activation_stream_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] func_sel = 3'd0;
    logic       busy, err_overflow;
    int         checks = 0;
    int         errors = 0;
    int         s, r, k;
    logic       saw_last;

    activation_stream_unit_if #(.DATA_WIDTH(8), .LANES(4)) up_if ();
    activation_stream_unit_if #(.DATA_WIDTH(8), .LANES(4)) dn_if ();

    activation_stream_unit #(.DATA_WIDTH(8), .LANES(4), .MAX_BEATS(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .func_sel     (func_sel),
        .up           (up_if),
        .dn           (dn_if),
        .busy         (busy),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One single-beat vector through PASS, checked one cycle after acceptance
    task automatic pw_test(input string tag, input logic [2:0] f, input logic [31:0] d,
                           input logic [31:0] exp);
        @(negedge clk);
        func_sel = f; up_if.valid = 1'b1; up_if.data = d; up_if.keep = 4'hf; up_if.last = 1'b1;
        dn_if.ready = 1'b1;
        @(negedge clk);
        up_if.valid = 1'b0;
        chk({tag, "_valid"}, 32'(dn_if.valid), 32'd1);
        chk({tag, "_data"}, dn_if.data, exp);
        chk({tag, "_last"}, 32'(dn_if.last), 32'd1);
    endtask

    initial begin
        up_if.valid = 1'b0; up_if.data = '0; up_if.keep = '0; up_if.last = 1'b0;
        dn_if.ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(dn_if.valid), 32'd0);
        chk("rst_in_ready", 32'(up_if.ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err_overflow), 32'd0);
        chk("rst_out_data", dn_if.data, 32'd0);
        rst = 1'b0;

        pw_test("relu", 3'd0, pack4(-5, 0, 7, 127), pack4(0, 0, 7, 127));
        pw_test("sigmoid", 3'd1, pack4(-65, -64, -1, 64), pack4(-96, -32, -32, 96));
        pw_test("tanh", 3'd2, pack4(-65, -64, -1, 64), pack4(-112, -48, -48, 112));
        pw_test("reserved7", 3'd7, pack4(-5, 0, 7, 127), pack4(0, 0, 7, 127));
`ifdef ACT_LEAKY_RELU_EN
        pw_test("leaky", 3'd4, pack4(-16, -1, 8, -128), pack4(-2, -1, 8, -16));
`else
        pw_test("leaky_off", 3'd4, pack4(-16, -1, 8, -128), pack4(0, 0, 8, 0));
`endif
        @(negedge clk);
        chk("pw_idle_busy", 32'(busy), 32'd0);
        chk("pw_idle_valid", 32'(dn_if.valid), 32'd0);

        // Softmax, two beats, second beat keeps lanes 0-1 only; max = 9
        func_sel = 3'd3; up_if.valid = 1'b1; up_if.data = pack4(1, 5, -128, 3);
        up_if.keep = 4'hf; up_if.last = 1'b0;
        @(negedge clk);
        func_sel = 3'd0; up_if.data = pack4(2, 9, 0, 0); up_if.keep = 4'h3; up_if.last = 1'b1;
        @(negedge clk);
        up_if.valid = 1'b0;
        chk("sm_in_ready_low", 32'(up_if.ready), 32'd0);
        chk("sm_busy", 32'(busy), 32'd1);
        chk("sm_no_out_yet", 32'(dn_if.valid), 32'd0);
        @(negedge clk);
        chk("sm_b0_valid", 32'(dn_if.valid), 32'd1);
        chk("sm_b0_data", dn_if.data, pack4(-8, -4, -128, -6));
        chk("sm_b0_last", 32'(dn_if.last), 32'd0);
        dn_if.ready = 1'b0;
        @(negedge clk);
        chk("sm_hold_data", dn_if.data, pack4(-8, -4, -128, -6));
        chk("sm_hold_valid", 32'(dn_if.valid), 32'd1);
        dn_if.ready = 1'b1;
        @(negedge clk);
        chk("sm_b1_data", dn_if.data, pack4(-7, 0, 0, 0));
        chk("sm_b1_keep", 32'(dn_if.keep), 32'h3);
        chk("sm_b1_last", 32'(dn_if.last), 32'd1);
        @(negedge clk);
        chk("sm_done_valid", 32'(dn_if.valid), 32'd0);
        chk("sm_done_ready", 32'(up_if.ready), 32'd1);
        chk("sm_done_busy", 32'(busy), 32'd0);

        // Softmax overflow: 16 beats without last, lane 0 = i, max = 15
        func_sel = 3'd3;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            up_if.valid = 1'b1; up_if.data = pack4(i, 0, 0, 0); up_if.keep = 4'h1; up_if.last = 1'b0;
        end
        @(negedge clk);
        up_if.data = pack4(16, 0, 0, 0);
        chk("ovf_err_pulse", 32'(err_overflow), 32'd1);
        chk("ovf_in_ready_low", 32'(up_if.ready), 32'd0);
        up_if.valid = 1'b0;
        @(negedge clk);
        chk("ovf_err_cleared", 32'(err_overflow), 32'd0);
        k = 0; saw_last = 1'b0;
        for (int c = 0; c < 40 && !saw_last; c++) begin
            if (c > 0) @(negedge clk);
            if (dn_if.valid) begin
                chk("ovf_data", dn_if.data, pack4(k - 15, 0, 0, 0));
                k++;
                if (dn_if.last) saw_last = 1'b1;
            end
        end
        chk("ovf_beats_out", 32'(k), 32'd16);
        chk("ovf_final_last", 32'(saw_last), 32'd1);
        @(negedge clk);

        // PASS with downstream ready toggling 1,0,1,0
        func_sel = 3'd0; s = 0; r = 0;
        for (int c = 0; c < 40 && r < 8; c++) begin
            @(negedge clk);
            dn_if.ready = (c % 2 == 0);
            up_if.valid = (s < 8);
            up_if.data  = pack4(s + 1, s + 10, s + 20, s + 30);
            up_if.keep  = 4'hf;
            up_if.last  = (s == 7);
            #1;
            if (dn_if.valid && dn_if.ready) begin
                chk("pass_order", dn_if.data, pack4(r + 1, r + 10, r + 20, r + 30));
                chk("pass_last", 32'(dn_if.last), 32'(r == 7));
                r++;
            end
            if (up_if.valid && up_if.ready) s++;
        end
        up_if.valid = 1'b0;
        chk("pass_count", 32'(r), 32'd8);
        @(negedge clk);
        dn_if.ready = 1'b1;
        chk("pass_no_dup", 32'(dn_if.valid), 32'd0);
        chk("pass_idle", 32'(busy), 32'd0);

        // Reset asserted mid-DRAIN with downstream stalled
        dn_if.ready = 1'b0; func_sel = 3'd3;
        up_if.valid = 1'b1; up_if.data = pack4(1, 5, -128, 3); up_if.keep = 4'hf; up_if.last = 1'b0;
        @(negedge clk);
        up_if.data = pack4(2, 9, 0, 0); up_if.keep = 4'h3; up_if.last = 1'b1;
        @(negedge clk);
        up_if.valid = 1'b0;
        @(negedge clk);
        chk("rd_draining", 32'(dn_if.valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("rd_out_valid", 32'(dn_if.valid), 32'd0);
        chk("rd_in_ready", 32'(up_if.ready), 32'd1);
        chk("rd_busy", 32'(busy), 32'd0);
        chk("rd_err", 32'(err_overflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dn_if.ready = 1'b1;
        @(negedge clk);
        chk("rd_after_valid", 32'(dn_if.valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
